// File: rtl/comm_arbiter.sv
// -----------------------------------------------------------------------------
// comm_arbiter
//
// Arbitrates between three serial engines (UART, SPI, I2C). Each engine
// signals that it has a result byte ready. The arbiter grants one engine,
// captures its byte and sends that byte to the host over a shared 4-bit
// ready/valid bus, high nibble first.
//
// A nibble that waits HOLD_MAX cycles for the host is abandoned. The whole
// byte is then dropped and a one-cycle drop pulse is raised.
//
// Build option:
//   COMM_ARB_FIXED_PRIO_EN  when defined, fixed priority I2C > SPI > UART
//                           and no round-robin pointer. When undefined
//                           (default), round-robin arbitration.
//
// Parameters:
//   HOLD_MAX   1..255  stall cycles tolerated per nibble before the drop
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req[2:0]   in   byte-ready level per engine (0 UART, 1 SPI, 2 I2C)
//   data_u     in   UART result byte, valid while req[0] is high
//   data_s     in   SPI result byte, valid while req[1] is high
//   data_i     in   I2C result byte, valid while req[2] is high
//   ack[2:0]   out  one-cycle capture pulse to the granted engine
//   nib_out    out  nibble on the host bus
//   nib_valid  out  nib_out is valid
//   nib_ready  in   host accepts the nibble when nib_valid is also high
//   nib_last   out  the low (second) nibble is being presented
//   src_id     out  source of the byte in flight (0 UART, 1 SPI, 2 I2C)
//   drop       out  one-cycle pulse when a byte is abandoned on timeout
//   busy       out  arbiter is not idle
// -----------------------------------------------------------------------------
module comm_arbiter #(
    parameter int HOLD_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] data_u,
    input  logic [7:0] data_s,
    input  logic [7:0] data_i,
    output logic [2:0] ack,
    output logic [3:0] nib_out,
    output logic       nib_valid,
    input  logic       nib_ready,
    output logic       nib_last,
    output logic [1:0] src_id,
    output logic       drop,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    logic [1:0] state;
    logic [3:0] lo_nib;      // only the low nibble needs keeping past the grant
    logic [7:0] hold_cnt;

    logic       xfer;
    logic       timeout;
    logic       grant_en;
    logic [1:0] grant;
    logic [7:0] grant_byte;

    // -------------------------------------------------------------------------
    // Status decode
    // -------------------------------------------------------------------------
    assign nib_valid = (state == ST_HI) || (state == ST_LO);
    assign nib_last  = (state == ST_LO);
    assign busy      = (state != ST_IDLE);

    assign xfer      = nib_valid && nib_ready;
    assign timeout   = nib_valid && (hold_cnt == HOLD_LIMIT);
    // A transfer in the same cycle as the timeout wins.
    assign drop      = timeout && !xfer;

    assign grant_en  = (state == ST_IDLE) && (req != 3'b000);

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
`ifdef COMM_ARB_FIXED_PRIO_EN
    always_comb begin
        if (req[2]) begin
            grant = 2'd2;
        end else if (req[1]) begin
            grant = 2'd1;
        end else begin
            grant = 2'd0;
        end
    end
`else
    logic [1:0] last;
    logic [1:0] ord0;
    logic [1:0] ord1;
    logic [1:0] ord2;

    // Search order begins one past the last winner and wraps modulo 3.
    always_comb begin
        case (last)
            2'd0: begin
                ord0 = 2'd1;
                ord1 = 2'd2;
                ord2 = 2'd0;
            end
            2'd1: begin
                ord0 = 2'd2;
                ord1 = 2'd0;
                ord2 = 2'd1;
            end
            default: begin
                ord0 = 2'd0;
                ord1 = 2'd1;
                ord2 = 2'd2;
            end
        endcase

        // With req != 0 and the first two candidates idle, the third must be
        // requesting, so a grant never targets a low req bit.
        if (req[ord0]) begin
            grant = ord0;
        end else if (req[ord1]) begin
            grant = ord1;
        end else begin
            grant = ord2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 2'd2;
        end else if (grant_en) begin
            last <= grant;
        end
    end
`endif

    always_comb begin
        case (grant)
            2'd1:    grant_byte = data_s;
            2'd2:    grant_byte = data_i;
            default: grant_byte = data_u;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            lo_nib   <= '0;
            hold_cnt <= '0;
            ack      <= '0;
            nib_out  <= '0;
            src_id   <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        state    <= ST_HI;
                        lo_nib   <= grant_byte[3:0];
                        nib_out  <= grant_byte[7:4];
                        src_id   <= grant;
                        ack      <= 3'b001 << grant;
                        hold_cnt <= '0;
                    end
                end

                ST_HI: begin
                    if (xfer) begin
                        state    <= ST_LO;
                        nib_out  <= lo_nib;
                        hold_cnt <= '0;
                    end else if (timeout) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                ST_LO: begin
                    if (xfer) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else if (timeout) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_comm_arbiter
//
// Scoreboard bench for comm_arbiter, built with HOLD_MAX = 4. Each grant
// pushes the expected ack and the expected host-bus events (nibbles or drop)
// into queues. A negedge monitor pops and compares them whenever the DUT acks,
// transfers a nibble or drops a byte. Directed checks cover latency, timeout
// and reset timing.
// -----------------------------------------------------------------------------
module tb_comm_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [7:0] data_u;
    logic [7:0] data_s;
    logic [7:0] data_i;
    logic [2:0] ack;
    logic [3:0] nib_out;
    logic       nib_valid;
    logic       nib_ready;
    logic       nib_last;
    logic [1:0] src_id;
    logic       drop;
    logic       busy;

    comm_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_u    (data_u),
        .data_s    (data_s),
        .data_i    (data_i),
        .ack       (ack),
        .nib_out   (nib_out),
        .nib_valid (nib_valid),
        .nib_ready (nib_ready),
        .nib_last  (nib_last),
        .src_id    (src_id),
        .drop      (drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_drop;
        logic [3:0] nib;
        logic       last;
        logic [1:0] src;
    } ev_t;

    ev_t        ev_q[$];
    logic [2:0] ack_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] m_last;
    int         order_exp [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: scan the candidate indices in priority order.
    function automatic logic [1:0] model_grant(input logic [2:0] r, input logic [1:0] lst);
`ifdef COMM_ARB_FIXED_PRIO_EN
        for (int i = 2; i >= 0; i--) begin
            if (r[i]) return 2'(i);
        end
        return 2'd0;
`else
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (int'(lst) + k) % 3;
            if (r[idx]) return 2'(idx);
        end
        return 2'd0;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Monitor: ack and host-bus events against the scoreboard
    // -------------------------------------------------------------------------
    ev_t        mon_ev;
    logic [2:0] mon_ack;

    always @(negedge clk) begin
        if (!reset) begin
            if (ack !== 3'b000) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", ack, 0);
                end else begin
                    mon_ack = ack_q.pop_front();
                    check("ack_value", ack, mon_ack);
                end
            end
            if ((nib_valid && nib_ready) || drop) begin
                if (ev_q.size() == 0) begin
                    check("event_unexpected", ev_q.size(), 1);
                end else begin
                    mon_ev = ev_q.pop_front();
                    check("event_drop", drop, mon_ev.is_drop);
                    check("event_src", src_id, mon_ev.src);
                    if (!mon_ev.is_drop) begin
                        check("event_nib", nib_out, mon_ev.nib);
                        check("event_last", nib_last, mon_ev.last);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all driving happens 1 time unit after a rising edge)
    // -------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            step(1);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    // mode 0: full byte expected, 1: drop expected, 2: only the high nibble
    task automatic send(input logic [2:0] r, input logic [7:0] du, input logic [7:0] ds,
                        input logic [7:0] di, input int mode);
        logic [1:0] g;
        logic [7:0] b;
        wait_idle();
        data_u = du;
        data_s = ds;
        data_i = di;
        req    = r;
        g = model_grant(r, m_last);
        m_last = g;
        b = (g == 2'd0) ? du : (g == 2'd1) ? ds : di;
        ack_q.push_back(3'b001 << g);
        if (mode == 1) begin
            ev_q.push_back('{is_drop: 1'b1, nib: 4'h0, last: 1'b0, src: g});
        end else begin
            ev_q.push_back('{is_drop: 1'b0, nib: b[7:4], last: 1'b0, src: g});
            if (mode == 0) ev_q.push_back('{is_drop: 1'b0, nib: b[3:0], last: 1'b1, src: g});
        end
        step(1);
        check("ack_latency", ack, 3'b001 << g);
        check("valid_latency", nib_valid, 1);
        step(1);
        check("ack_pulse", ack, 0);
        req = 3'b000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_nib"}, nib_out, 0);
        check({tag, "_valid"}, nib_valid, 0);
        check({tag, "_last"}, nib_last, 0);
        check({tag, "_src"}, src_id, 0);
        check({tag, "_drop"}, drop, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
`ifdef COMM_ARB_FIXED_PRIO_EN
        order_exp = '{2, 2, 2, 2};
`else
        order_exp = '{0, 1, 2, 0};
`endif
        reset     = 1'b1;
        req       = 3'b000;
        data_u    = 8'h00;
        data_s    = 8'h00;
        data_i    = 8'h00;
        nib_ready = 1'b0;
        m_last    = 2'd2;
        step(2);
        check_all_zero("reset");
        reset = 1'b0;
        step(1);

        // All engines requesting and re-raising after every ack.
        nib_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(3'b111, 8'h11, 8'h22, 8'h33, 0);
            check("rr_order", src_id, order_exp[i]);
        end
        wait_idle();

        // Single UART byte with the host always ready.
        send(3'b001, 8'hA5, 8'h00, 8'h00, 0);
        check("t1_lo_last", nib_last, 1);
        check("t1_lo_nib", nib_out, 4'h5);
        step(1);
        check("t1_busy_n3", busy, 0);
        check("t1_valid_idle", nib_valid, 0);
        check("t1_nib_hold", nib_out, 4'h5);
        check("t1_src", src_id, 0);

        // Host stalls the high nibble until the hold timeout.
        nib_ready = 1'b0;
        send(3'b001, 8'hC7, 8'h00, 8'h00, 1);
        step(3);
        check("t3_drop_pulse", drop, 1);
        check("t3_still_hi", nib_last, 0);
        check("t3_busy", busy, 1);
        step(1);
        check("t3_drop_clear", drop, 0);
        check("t3_idle", busy, 0);
        check("t3_no_lo", nib_valid, 0);
        check("t3_nib_hold", nib_out, 4'hC);

        // Host becomes ready in the same cycle the count reaches the limit.
        send(3'b100, 8'h00, 8'h00, 8'h96, 0);
        step(3);
        nib_ready = 1'b1;
        #1;
        check("t4_no_drop", drop, 0);
        check("t4_hi", nib_last, 0);
        step(1);
        check("t4_lo_entered", nib_last, 1);
        check("t4_lo_nib", nib_out, 4'h6);
        check("t4_busy", busy, 1);
        step(1);
        check("t4_done", busy, 0);

        // Reset while the SPI low nibble is stalled.
        send(3'b010, 8'h00, 8'h3C, 8'h00, 2);
        nib_ready = 1'b0;
        check("t5_in_lo", nib_last, 1);
        check("t5_lo_nib", nib_out, 4'hC);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t5_async");
        m_last = 2'd2;
        step(2);
        reset = 1'b0;
        step(2);
        check("t5_not_reissued", nib_valid, 0);
        check("t5_idle", busy, 0);
        nib_ready = 1'b1;
        send(3'b010, 8'h00, 8'h3C, 8'h00, 0);
        wait_idle();
        check("t5_src", src_id, 1);

        // req changes while busy are ignored, and the hold count restarts per nibble.
        nib_ready = 1'b0;
        send(3'b001, 8'h5A, 8'h00, 8'h00, 0);
        req = 3'b110;
        step(1);
        req = 3'b011;
        check("t6_nib_hi", nib_out, 4'h5);
        check("t6_src_hi", src_id, 0);
        check("t6_hi", nib_last, 0);
        step(1);
        nib_ready = 1'b1;
        req = 3'b101;
        check("t6_nib_hi2", nib_out, 4'h5);
        step(1);
        nib_ready = 1'b0;
        check("t6_lo", nib_last, 1);
        check("t6_nib_lo", nib_out, 4'hA);
        req = 3'b111;
        step(3);
        check("t6_no_drop", drop, 0);
        check("t6_busy_lo", busy, 1);
        check("t6_src_lo", src_id, 0);
        nib_ready = 1'b1;
        req = 3'b000;
        step(1);
        check("t6_idle", busy, 0);
        check("t6_nib_hold", nib_out, 4'hA);
        check("t6_src_hold", src_id, 0);
        check("t6_valid_idle", nib_valid, 0);

        step(3);
        check("ack_q_left", ack_q.size(), 0);
        check("ev_q_left", ev_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
